// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: constants and types shared between the chip8 interpreter
// and the program loader.
//   - ADDR_WIDTH / DATA_WIDTH : program memory geometry
//   - LOAD_BASE / MAX_LEN     : where a loaded image starts and its largest size
//   - SYNC_BYTE               : frame start marker on the UART byte stream
//   - TIMEOUT                 : idle cycles tolerated between bytes of a frame
//   - ld_state_e              : loader state encoding
//   - len_legal()             : frame length acceptance rule
package prog_loader_pkg;

  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned LOAD_BASE  = 512;
  localparam int unsigned MAX_LEN    = 4096 - LOAD_BASE;
  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
  // 10 ms at 25.125 MHz.
  localparam int unsigned TIMEOUT    = 251250;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_H,
    LD_LEN_L,
    LD_DATA,
    LD_CSUM,
    LD_DONE,
    LD_ERR
  } ld_state_e;

  // A frame must carry at least one byte and must fit between LOAD_BASE and
  // the top of memory.
  function automatic logic len_legal(input logic [15:0] len,
                                     input int unsigned max_len);
    return (len != 16'd0) && ({16'd0, len} <= max_len);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream in, program memory write port and interpreter
// control out.
//   rx_i, rx_i_v          : UART byte and single-cycle valid strobe
//   mem_we, mem_waddr,
//   mem_d                 : program memory write port
//   cpu_hold, cpu_rst     : interpreter stall and restart pulse
//   load_done, load_err   : frame accepted pulse / sticky error flag
// Modports: master = byte source and consumer of the results,
//           slave  = the loader itself.
interface prog_loader_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
);

  logic [7:0]            rx_i;
  logic                  rx_i_v;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_d;
  logic                  cpu_hold;
  logic                  cpu_rst;
  logic                  load_done;
  logic                  load_err;

  modport master (
    output rx_i, rx_i_v,
    input  mem_we, mem_waddr, mem_d, cpu_hold, cpu_rst, load_done, load_err
  );

  modport slave (
    input  rx_i, rx_i_v,
    output mem_we, mem_waddr, mem_d, cpu_hold, cpu_rst, load_done, load_err
  );

endinterface

// File: rtl/prog_loader_byte_timeout.sv
// byte_timeout: inter-byte watchdog for UART-facing blocks.
//   clk, rst : clock and synchronous active-high reset
//   en       : watchdog armed (counter held at zero while low)
//   kick     : a byte arrived this cycle; restarts the count
//   expired  : high once TIMEOUT cycles have passed with no kick while armed
module byte_timeout #(
  parameter int unsigned TIMEOUT = prog_loader_pkg::TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst || !en || kick) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + CW'(1);
    end
  end

  // A byte in the same cycle wins over expiry.
  assign expired = en && !kick && (cnt == LIMIT);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: parses framed program images from the UART byte stream
//   frame = SYNC_BYTE, LEN_H, LEN_L, LEN payload bytes, CSUM (sum mod 256)
// and writes the payload into program memory from LOAD_BASE upward. The
// interpreter is held while a load is in flight and restarted with a
// one-cycle cpu_rst pulse after a good load; a failed load leaves it held
// with load_err set until the next SYNC_BYTE.
//   clk, rst : clock, synchronous active-high reset
//   bus      : prog_loader_if.slave (byte input, memory write port, status)
module prog_loader #(
  parameter int unsigned ADDR_WIDTH = prog_loader_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = prog_loader_pkg::DATA_WIDTH,
  parameter int unsigned LOAD_BASE  = prog_loader_pkg::LOAD_BASE,
  parameter int unsigned MAX_LEN    = prog_loader_pkg::MAX_LEN,
  parameter logic [7:0]  SYNC_BYTE  = prog_loader_pkg::SYNC_BYTE,
  parameter int unsigned TIMEOUT    = prog_loader_pkg::TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus
);

  import prog_loader_pkg::*;

  ld_state_e             state;
  logic [7:0]            len_h;
  logic [15:0]           remaining;
  logic [7:0]            checksum;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  in_frame;
  logic                  timed_out;

  // Only the states that wait on the sender are subject to the watchdog.
  assign in_frame = (state == LD_LEN_H) || (state == LD_LEN_L) ||
                    (state == LD_DATA)  || (state == LD_CSUM);

  byte_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .en      (in_frame),
    .kick    (bus.rx_i_v),
    .expired (timed_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LD_IDLE;
      len_h         <= '0;
      remaining     <= '0;
      checksum      <= '0;
      wr_addr       <= ADDR_WIDTH'(LOAD_BASE);
      bus.mem_we    <= 1'b0;
      bus.mem_waddr <= ADDR_WIDTH'(LOAD_BASE);
      bus.mem_d     <= '0;
      bus.cpu_hold  <= 1'b0;
      bus.cpu_rst   <= 1'b0;
      bus.load_done <= 1'b0;
      bus.load_err  <= 1'b0;
    end else begin
      // Pulse outputs default low; the states below raise them for one cycle.
      bus.mem_we    <= 1'b0;
      bus.cpu_rst   <= 1'b0;
      bus.load_done <= 1'b0;

      case (state)
        LD_IDLE: begin
          if (bus.rx_i_v && bus.rx_i == SYNC_BYTE) begin
            state        <= LD_LEN_H;
            bus.cpu_hold <= 1'b1;
            bus.load_err <= 1'b0;
            checksum     <= '0;
          end
        end

        LD_LEN_H: begin
          if (bus.rx_i_v) begin
            len_h <= bus.rx_i;
            state <= LD_LEN_L;
          end else if (timed_out) begin
            state        <= LD_ERR;
            bus.load_err <= 1'b1;
          end
        end

        LD_LEN_L: begin
          if (bus.rx_i_v) begin
            if (len_legal({len_h, bus.rx_i}, MAX_LEN)) begin
              state         <= LD_DATA;
              remaining     <= {len_h, bus.rx_i};
              wr_addr       <= ADDR_WIDTH'(LOAD_BASE);
              bus.mem_waddr <= ADDR_WIDTH'(LOAD_BASE);
            end else begin
              state        <= LD_ERR;
              bus.load_err <= 1'b1;
            end
          end else if (timed_out) begin
            state        <= LD_ERR;
            bus.load_err <= 1'b1;
          end
        end

        LD_DATA: begin
          if (bus.rx_i_v) begin
            // Write port is registered: the byte appears on the bus one
            // cycle after it arrives, tagged with the pre-increment address.
            bus.mem_we    <= 1'b1;
            bus.mem_d     <= DATA_WIDTH'(bus.rx_i);
            bus.mem_waddr <= wr_addr;
            wr_addr       <= wr_addr + ADDR_WIDTH'(1);
            checksum      <= checksum + bus.rx_i;
            remaining     <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state <= LD_CSUM;
            end
          end else if (timed_out) begin
            state        <= LD_ERR;
            bus.load_err <= 1'b1;
          end
        end

        LD_CSUM: begin
          if (bus.rx_i_v) begin
            if (bus.rx_i == checksum) begin
              state         <= LD_DONE;
              bus.load_done <= 1'b1;
              bus.cpu_rst   <= 1'b1;
            end else begin
              state        <= LD_ERR;
              bus.load_err <= 1'b1;
            end
          end else if (timed_out) begin
            state        <= LD_ERR;
            bus.load_err <= 1'b1;
          end
        end

        // cpu_rst is already high during this cycle, so releasing the hold
        // now lets the restart overlap the last held cycle.
        LD_DONE: begin
          bus.cpu_hold <= 1'b0;
          state        <= LD_IDLE;
        end

        // Memory may be partially overwritten: keep the interpreter held.
        LD_ERR: begin
          state <= LD_IDLE;
        end

        default: begin
          state <= LD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized and directed frames against a frame-level model.
// The model schedules, per sampling edge, the writes and status changes each
// frame must produce; one compare process checks every DUT output each cycle.
module tb_prog_loader;

  import prog_loader_pkg::*;

  localparam int TB_TIMEOUT = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus ();

  prog_loader #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // cyc = number of rising edges so far; stable at every falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t wr_exp      [int];
  bit  done_at     [int];
  bit  sync_at     [int];
  bit  hold_clr_at [int];
  bit  err_at      [int];
  bit  rst_at      [int];

  bit m_hold = 1'b0;
  bit m_err  = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int crst_cnt = 0;
  int err_rise_cyc = -1;
  logic prev_err = 1'b0;
  logic [7:0] mem_img [0:4095];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] csum_of(input logic [7:0] pl[$]);
    int s = 0;
    foreach (pl[i]) s += int'(pl[i]);
    return 8'(s % 256);
  endfunction

  // Compare process: apply scheduled model events for this cycle, then check.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst_at.exists(cyc)) begin
        m_hold = 1'b0;
        m_err  = 1'b0;
        check("rst_waddr", 32'(bus.mem_waddr), LOAD_BASE);
        check("rst_mem_d", 32'(bus.mem_d), 32'd0);
      end else begin
        if (sync_at.exists(cyc)) begin
          m_hold = 1'b1;
          m_err  = 1'b0;
        end
        if (err_at.exists(cyc))      m_err  = 1'b1;
        if (hold_clr_at.exists(cyc)) m_hold = 1'b0;
      end
      check("mem_we", 32'(bus.mem_we), 32'(wr_exp.exists(cyc)));
      if (bus.mem_we === 1'b1 && wr_exp.exists(cyc)) begin
        check("mem_waddr", 32'(bus.mem_waddr), 32'(wr_exp[cyc].a));
        check("mem_d", 32'(bus.mem_d), 32'(wr_exp[cyc].d));
      end
      if (bus.mem_we === 1'b1) begin
        mem_img[bus.mem_waddr] = bus.mem_d;
        wr_cnt++;
      end
      check("load_done", 32'(bus.load_done), 32'(done_at.exists(cyc)));
      check("cpu_rst", 32'(bus.cpu_rst), 32'(done_at.exists(cyc)));
      check("cpu_hold", 32'(bus.cpu_hold), 32'(m_hold));
      check("load_err", 32'(bus.load_err), 32'(m_err));
      if (bus.load_done === 1'b1) done_cnt++;
      if (bus.cpu_rst === 1'b1)   crst_cnt++;
      if (bus.load_err === 1'b1 && prev_err !== 1'b1) err_rise_cyc = cyc;
      prev_err = bus.load_err;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; returns the rising edge that samples the byte.
  task automatic send_byte(input logic [7:0] b, input int gap, output int e);
    repeat (gap) @(negedge clk);
    bus.rx_i   = b;
    bus.rx_i_v = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    bus.rx_i_v = 1'b0;
  endtask

  // n_send < 0 sends the whole frame; otherwise the frame is cut short and
  // the watchdog must end it TB_TIMEOUT+1 cycles after the last byte.
  task automatic send_frame(input int len_field, input logic [7:0] pl[$],
                            input logic [7:0] csum, input int n_send,
                            input int max_gap, output int last_e);
    logic [7:0] fr[$];
    int e;
    int n;
    bit legal;
    legal = (len_field >= 1) && (len_field <= int'(MAX_LEN));
    fr = {SYNC_BYTE, 8'(len_field >> 8), 8'(len_field)};
    if (legal) begin
      foreach (pl[i]) fr.push_back(pl[i]);
      fr.push_back(csum);
    end
    n = (n_send < 0 || n_send > fr.size()) ? fr.size() : n_send;
    e = 0;
    for (int i = 0; i < n; i++) begin
      send_byte(fr[i], (i == 0) ? 0 : $urandom_range(max_gap), e);
      if (i == 0) begin
        sync_at[e] = 1'b1;
      end else if (i == 2 && !legal) begin
        err_at[e] = 1'b1;
      end else if (i >= 3 && i < 3 + len_field) begin
        wr_exp[e] = '{a: 12'(int'(LOAD_BASE) + i - 3), d: fr[i]};
      end else if (i == 3 + len_field) begin
        if (fr[i] == csum_of(pl)) begin
          done_at[e]       = 1'b1;
          hold_clr_at[e+1] = 1'b1;
        end else begin
          err_at[e] = 1'b1;
        end
      end
    end
    last_e = e;
    if (n < fr.size()) begin
      err_at[e + TB_TIMEOUT + 1] = 1'b1;
      while (cyc < e + TB_TIMEOUT + 3) @(negedge clk);
    end
    idle(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] cs;
    logic [7:0] b;
    int e, le, w0, d0, r0, kind, len, nsend;

    bus.rx_i   = 8'h00;
    bus.rx_i_v = 1'b0;
    rst_at[1]  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1;
      rst_at[cyc+1] = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    idle(2);

    // Pin the model's checksum arithmetic with hand-computed values.
    q = {8'h12, 8'h34, 8'h56};
    check("model_csum_good", 32'(csum_of(q)), 32'h9C);
    q = {8'hAA, 8'hBB};
    check("model_csum_bad", 32'(csum_of(q)), 32'h65);

    // Good frame.
    w0 = wr_cnt; d0 = done_cnt; r0 = crst_cnt;
    q = {8'h12, 8'h34, 8'h56};
    send_frame(3, q, 8'h9C, -1, 0, le);
    check("good_0x200", 32'(mem_img[12'h200]), 32'h12);
    check("good_0x201", 32'(mem_img[12'h201]), 32'h34);
    check("good_0x202", 32'(mem_img[12'h202]), 32'h56);
    check("good_writes", 32'(wr_cnt - w0), 32'd3);
    check("good_done", 32'(done_cnt - d0), 32'd1);
    check("good_cpu_rst", 32'(crst_cnt - r0), 32'd1);
    check("good_hold", 32'(bus.cpu_hold), 32'd0);
    check("good_err", 32'(bus.load_err), 32'd0);

    // Bad checksum.
    w0 = wr_cnt; r0 = crst_cnt;
    q = {8'hAA, 8'hBB};
    send_frame(2, q, 8'h00, -1, 1, le);
    check("badcs_writes", 32'(wr_cnt - w0), 32'd2);
    check("badcs_err", 32'(bus.load_err), 32'd1);
    check("badcs_hold", 32'(bus.cpu_hold), 32'd1);
    check("badcs_cpu_rst", 32'(crst_cnt - r0), 32'd0);

    // Illegal lengths: 3585 and 0.
    w0 = wr_cnt;
    q = {};
    send_frame(3585, q, 8'h00, -1, 0, le);
    check("len3585_err", 32'(bus.load_err), 32'd1);
    send_frame(0, q, 8'h00, -1, 0, le);
    check("len0_err", 32'(bus.load_err), 32'd1);
    check("badlen_writes", 32'(wr_cnt - w0), 32'd0);

    // Timeout after two of four payload bytes, then a good frame.
    q = {8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(4, q, csum_of(q), 5, 0, le);
    check("timeout_latency", 32'(err_rise_cyc - le), 32'(TB_TIMEOUT + 1));
    check("timeout_err", 32'(bus.load_err), 32'd1);
    d0 = done_cnt;
    q = {8'h5A};
    send_frame(1, q, 8'h5A, -1, 0, le);
    check("after_to_err", 32'(bus.load_err), 32'd0);
    check("after_to_done", 32'(done_cnt - d0), 32'd1);

    // Noise, then a one-byte frame.
    w0 = wr_cnt;
    send_byte(8'h00, 0, e);
    send_byte(8'hFF, 1, e);
    send_byte(8'h13, 0, e);
    idle(2);
    q = {8'h7E};
    send_frame(1, q, 8'h7E, -1, 0, le);
    check("noise_0x200", 32'(mem_img[12'h200]), 32'h7E);
    check("noise_writes", 32'(wr_cnt - w0), 32'd1);

    // Reset after two of five payload bytes.
    w0 = wr_cnt;
    send_byte(SYNC_BYTE, 0, e); sync_at[e] = 1'b1;
    send_byte(8'h00, 0, e);
    send_byte(8'h05, 0, e);
    send_byte(8'h11, 0, e); wr_exp[e] = '{a: 12'h200, d: 8'h11};
    send_byte(8'h22, 0, e); wr_exp[e] = '{a: 12'h201, d: 8'h22};
    rst = 1'b1;
    rst_at[cyc+1] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h33, 0, e);
    send_byte(8'h44, 1, e);
    send_byte(8'h55, 0, e);
    send_byte(8'hFF, 0, e);
    idle(TB_TIMEOUT + 5);
    check("rst_mid_writes", 32'(wr_cnt - w0), 32'd2);
    check("rst_mid_err", 32'(bus.load_err), 32'd0);
    check("rst_mid_hold", 32'(bus.cpu_hold), 32'd0);

    // Largest legal image reaches the top of memory.
    w0 = wr_cnt; d0 = done_cnt;
    q = {};
    for (int i = 0; i < int'(MAX_LEN); i++) q.push_back(8'($urandom_range(255)));
    send_frame(int'(MAX_LEN), q, csum_of(q), -1, 0, le);
    check("max_writes", 32'(wr_cnt - w0), MAX_LEN);
    check("max_top_byte", 32'(mem_img[12'hFFF]), 32'(q[MAX_LEN-1]));
    check("max_done", 32'(done_cnt - d0), 32'd1);

    // Randomized frames: good, bad checksum, bad length, truncated.
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(3);
      repeat ($urandom_range(2)) begin
        b = 8'($urandom_range(255));
        if (b == SYNC_BYTE) b = 8'h00;
        send_byte(b, $urandom_range(3), e);
      end
      idle(2);
      len = $urandom_range(1, 24);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(255)));
      cs = csum_of(q);
      nsend = -1;
      case (kind)
        1: cs = cs ^ 8'($urandom_range(1, 255));
        2: begin
          len = ($urandom_range(1) == 0) ? 0 : $urandom_range(int'(MAX_LEN) + 1, 65535);
          q = {};
        end
        3: nsend = $urandom_range(1, len + 3);
        default: ;
      endcase
      send_frame(len, q, cs, nsend, 3, le);
    end

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream stage of the chip8 interpreter. Consumes the byte stream from the UART receiver (rx_i / rx_i_v).
- Parses a framed program image and writes it into program memory starting at 0x200.
- Holds the interpreter while a load is in progress, then issues a one-cycle restart pulse so execution begins from pc = 512 with the new image.

Parameters:
- ADDR_WIDTH, 12, program memory address width.
- DATA_WIDTH, 8, memory data width.
- LOAD_BASE, 512, first address written.
- MAX_LEN, 3584, largest legal payload (4096 - LOAD_BASE).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 251250, idle cycles allowed between bytes inside a frame (10 ms at 25.125 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_i  in  8  received UART byte
- rx_i_v  in  1  rx_i valid, single-cycle strobe per byte
- mem_we  out  1  program memory write enable
- mem_waddr  out  ADDR_WIDTH  program memory write address
- mem_d  out  DATA_WIDTH  program memory write data
- cpu_hold  out  1  interpreter stall; high while a load is active or after a failed load
- cpu_rst  out  1  one-cycle interpreter restart pulse after a good load
- load_done  out  1  one-cycle pulse, frame accepted
- load_err  out  1  sticky error flag, cleared when the next SYNC_BYTE is accepted

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0; mem_waddr = LOAD_BASE; state = IDLE; length, checksum and timeout counters cleared.
- Frame format: SYNC_BYTE, LEN_H, LEN_L, LEN payload bytes, CSUM.
  - LEN is 16 bits, big-endian.
  - CSUM is the 8-bit modulo-256 sum of the payload bytes.
- States and transitions (a byte = a cycle with rx_i_v=1):
  - IDLE: a byte equal to SYNC_BYTE -> LEN_H. Also sets cpu_hold=1, clears load_err and checksum. Any other byte is ignored.
  - LEN_H: byte -> len[15:8]; next LEN_L.
  - LEN_L: byte -> len[7:0].
    - len==0 or len>MAX_LEN -> ERR.
    - Otherwise -> DATA, with mem_waddr=LOAD_BASE and remaining=len.
  - DATA: each byte drives mem_we=1, mem_d=byte, mem_waddr=current address on the next cycle (1-cycle latency). Address then increments, checksum += byte, remaining decrements. After the last byte -> CSUM.
  - CSUM: byte == checksum -> DONE; otherwise -> ERR.
  - DONE: one cycle.
    - Asserts load_done=1 and cpu_rst=1.
    - cpu_hold drops to 0 on the following cycle, i.e. cpu_rst overlaps the last hold cycle.
    - -> IDLE.
  - ERR: one cycle. Sets load_err=1; cpu_hold stays 1 (memory is partially overwritten); -> IDLE.
- Timeout: in LEN_H, LEN_L, DATA and CSUM, a counter counts cycles without rx_i_v and resets on each byte. Reaching TIMEOUT -> ERR.
- mem_we is high only for payload bytes, never for header or checksum bytes.
- Address never exceeds LOAD_BASE+MAX_LEN-1 = 0xFFF; no wrap is possible.
- SYNC_BYTE seen inside a frame is treated as ordinary data. Resynchronisation happens only via timeout or ERR.
- rx_i_v arriving in the DONE or ERR cycle: the byte is dropped. The sender must wait at least 2 cycles between frames; UART byte spacing guarantees this.
- rst mid-frame: immediate return to IDLE, cpu_hold=0, load_err=0. No further writes; memory content written so far is left as-is.
- Widths:
  - remaining counter: 16 bits.
  - checksum: 8 bits, wrapping.
  - timeout counter: $clog2(TIMEOUT+1) bits.

Decomposition:
- Shared chip8 header gets the state encodings (LD_IDLE..LD_ERR), SYNC_BYTE, LOAD_BASE (512) and MAX_LEN, so interpreter and loader agree on the program base.
- One sub-module is natural: byte_timeout. It takes clk, rst, en, kick and produces an expired pulse, and is reusable for later UART-facing blocks.
- Everything else stays in prog_loader.

Test Plan:
- Good frame: A5 00 03 12 34 56, CSUM=9C -> writes 0x200=12, 0x201=34, 0x202=56. One load_done pulse and one cpu_rst pulse; cpu_hold 1→0; load_err=0.
- Bad checksum: A5 00 02 AA BB 00 -> two writes occur; load_err=1 stays set; cpu_hold=1; no cpu_rst.
- Illegal length: A5 0E 01 (3585) -> ERR directly after LEN_L; zero writes; load_err=1. A5 00 00 gives the same result.
- Timeout: A5 00 04 01 02, then silence for TIMEOUT cycles -> load_err=1 at TIMEOUT+1 cycles after the last byte. A following good frame clears load_err and asserts load_done.
- Noise then sync: bytes 00 FF 13, then a good 1-byte frame A5 00 01 7E 7E -> only 0x200=7E is written. cpu_hold stays 0 until A5 arrives.
- Reset mid-DATA: assert rst after 2 of 5 payload bytes -> next cycle all outputs are at reset values. Later bytes produce no writes until a new A5 arrives.
